// File: rtl/matmul_apb_protocol_monitor.sv
// Passive APB3 protocol monitor for the matmul slave port.
// Tracks transfer phases, predicts pslverr from the register map and busy_o,
// checks start->busy latency and scratchpad targets, and reports sticky flags,
// pulses, saturating counters and the first violating cycle.
module matmul_apb_protocol_monitor #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned OFFS_W       = 5,
  parameter int unsigned NUM_WR_REGS  = 3,
  parameter int unsigned NUM_RD_REGS  = 5,
  parameter int unsigned SP_NTARGETS  = 4,
  parameter int unsigned BUSY_LAT_MAX = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic              pready_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [DATA_W-1:0] pwdata_i,
  input  logic              pslverr_o,
  input  logic              busy_o,
  input  logic              clr_i,
  output logic [7:0]        viol_o,
  output logic [7:0]        viol_pulse_o,
  output logic [CNT_W-1:0]  viol_cnt_o,
  output logic [CNT_W-1:0]  xfer_cnt_o,
  output logic              first_vld_o,
  output logic [2:0]        first_code_o,
  output logic [ADDR_W-1:0] first_addr_o
);

  localparam int unsigned BT_W = $clog2(BUSY_LAT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;
  logic [BT_W-1:0]     r_bt;
  logic [7:0]          r_viol;
  logic [7:0]          r_pulse;
  logic [CNT_W-1:0]    r_viol_cnt;
  logic [CNT_W-1:0]    r_xfer_cnt;
  logic                r_first_vld;
  logic [2:0]          r_first_code;
  logic [ADDR_W-1:0]   r_first_addr;

  logic                w_setup;
  logic                w_access;
  logic                w_in_xfer;
  logic                w_complete;
  logic [OFFS_W-1:0]   w_offs;
  logic [31:0]         w_idx;
  logic                w_legal;
  logic                w_exp_err;
  logic                w_offs0;
  logic                w_bad_tgt;
  logic                w_start;
  logic                w_any;
  logic [7:0]          w_viol;
  logic [2:0]          w_code;

  // Phase decode, error prediction and per-cycle violation vector
  always_comb begin
    w_setup    = psel_i & ~penable_i;
    w_access   = psel_i & penable_i;
    w_in_xfer  = (r_state != S_IDLE);
    w_complete = w_in_xfer & w_access & pready_i;
    w_offs     = paddr_i[OFFS_W-1:0];
    w_idx      = 32'(w_offs >> 2);
    w_legal    = (w_offs[1:0] == 2'b00) &
                 (pwrite_i ? (w_idx < NUM_WR_REGS) : (w_idx < NUM_RD_REGS));
    w_exp_err  = ~w_legal | (pwrite_i & busy_o);
    w_offs0    = (w_offs == '0);
    w_bad_tgt  = (32'(pwdata_i[3:2]) >= SP_NTARGETS) | (32'(pwdata_i[5:4]) >= SP_NTARGETS);
    w_start    = w_complete & pwrite_i & w_offs0 & pwdata_i[0] & ~busy_o & ~w_exp_err;

    w_viol    = '0;
    w_viol[0] = ((r_state == S_IDLE) & w_access) | ((r_state == S_SETUP) & w_setup);
    w_viol[1] = w_in_xfer & w_access &
                ((paddr_i != r_addr) | (pwrite_i != r_write) | (pwdata_i != r_wdata));
    w_viol[2] = ((r_state == S_SETUP) & ~psel_i) | ((r_state == S_WAIT) & ~w_access);
    w_viol[3] = w_complete & w_exp_err & ~pslverr_o;
    w_viol[4] = w_complete & ~w_exp_err & pslverr_o;
    w_viol[5] = (r_bt == BT_W'(1)) & ~busy_o;
    w_viol[6] = w_complete & pwrite_i & w_offs0 & w_bad_tgt;
    w_viol[7] = pslverr_o & ~w_access;
    w_any     = |w_viol;

    // scan high to low so the last hit is the lowest index
    w_code = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (w_viol[7-i]) w_code = 3'(7 - i);
    end
  end

  // APB phase tracker with address/control/data capture at setup
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_setup) begin
            r_state <= S_SETUP;
            r_addr  <= paddr_i;
            r_write <= pwrite_i;
            r_wdata <= pwdata_i;
          end
        end
        S_SETUP: begin
          if (w_access) begin
            r_state <= pready_i ? S_IDLE : S_WAIT;
          end else if (w_setup) begin
            r_state <= S_SETUP;
            r_addr  <= paddr_i;
            r_write <= pwrite_i;
            r_wdata <= pwdata_i;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (w_access) begin
            r_state <= pready_i ? S_IDLE : S_WAIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Start->busy latency timer; zero means idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bt <= '0;
    end else if (w_start) begin
      r_bt <= BT_W'(BUSY_LAT_MAX);
    end else if (r_bt != '0) begin
      r_bt <= busy_o ? '0 : r_bt - BT_W'(1);
    end
  end

  // Sticky flags, pulses, saturating counters and first-error capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_viol       <= '0;
      r_pulse      <= '0;
      r_viol_cnt   <= '0;
      r_xfer_cnt   <= '0;
      r_first_vld  <= 1'b0;
      r_first_code <= '0;
      r_first_addr <= '0;
    end else begin
      r_pulse <= w_viol;
      if (clr_i) begin
        // clear first, then let this cycle's events land on the cleared state
        r_viol       <= w_viol;
        r_viol_cnt   <= w_any ? CNT_W'(1) : '0;
        r_xfer_cnt   <= w_complete ? CNT_W'(1) : '0;
        r_first_vld  <= w_any;
        r_first_code <= w_any ? w_code : '0;
        r_first_addr <= w_any ? paddr_i : '0;
      end else begin
        r_viol <= r_viol | w_viol;
        if (w_any && (r_viol_cnt != '1)) r_viol_cnt <= r_viol_cnt + CNT_W'(1);
        if (w_complete && (r_xfer_cnt != '1)) r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
        if (w_any && !r_first_vld) begin
          r_first_vld  <= 1'b1;
          r_first_code <= w_code;
          r_first_addr <= paddr_i;
        end
      end
    end
  end

  assign viol_o       = r_viol;
  assign viol_pulse_o = r_pulse;
  assign viol_cnt_o   = r_viol_cnt;
  assign xfer_cnt_o   = r_xfer_cnt;
  assign first_vld_o  = r_first_vld;
  assign first_code_o = r_first_code;
  assign first_addr_o = r_first_addr;

endmodule
